// File: rtl/magphase_gain_ctrl_pkg.sv
// magphase_gain_pkg
// Shared constants and types for the magphase gain sequencer:
//   - default settings-bus addresses of the gain, commit and ramp registers
//   - FSM state encoding
//   - fixed-point layout of the ramp accumulators
//   - settings-bus field widths used by the interface
package magphase_gain_pkg;

    localparam int DEF_SR_MAG_GAIN   = 192;
    localparam int DEF_SR_PHASE_GAIN = 193;
    localparam int DEF_SR_COMMIT     = 194;
    localparam int DEF_SR_RAMP       = 195;

    localparam int SET_ADDR_W = 8;
    localparam int SET_DATA_W = 32;

    localparam int GAIN_W        = 16;
    localparam int FRAC_BITS     = 8;
    localparam int MAX_RAMP_LOG2 = 8;
    // Two guard bits above the 16-bit gain field keep the accumulator
    // sign-correct while it walks between two full-scale gains.
    localparam int ACC_W         = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RAMP  = 2'd2
    } state_e;

endpackage

// File: rtl/magphase_gain_ctrl_if.sv
// magphase_gain_ctrl_if
// Groups the settings-bus write port and the monitored AXI-stream
// handshake that the gain sequencer watches for packet boundaries.
//   set_stb / set_addr / set_data : settings write strobe, address, data
//   mon_tvalid / mon_tready / mon_tlast : observed stream handshake
// master: the side that produces these signals (noc_shell / testbench)
// slave : the gain sequencer, which only observes them
interface magphase_gain_ctrl_if;
    import magphase_gain_pkg::*;

    logic                  set_stb;
    logic [SET_ADDR_W-1:0] set_addr;
    logic [SET_DATA_W-1:0] set_data;
    logic                  mon_tvalid;
    logic                  mon_tready;
    logic                  mon_tlast;

    modport master (
        output set_stb, set_addr, set_data,
        output mon_tvalid, mon_tready, mon_tlast
    );

    modport slave (
        input set_stb, set_addr, set_data,
        input mon_tvalid, mon_tready, mon_tlast
    );

endinterface

// File: rtl/magphase_gain_ctrl_gain_ramp_chan.sv
// gain_ramp_chan
// One gain channel of the sequencer: a signed 26-bit accumulator with
// 8 fractional bits whose integer part is the live gain.
//   clk, rst_n    : clock, asynchronous active-low reset
//   apply_direct  : latch shadow as target and load it immediately
//   apply_ramp    : latch shadow as target, compute per-beat step, restart
//                   the accumulator from the current live gain
//   step_en       : add one step (one accepted ramp sample)
//   snap          : force the accumulator onto the target (final ramp step)
//   shadow        : newest shadow gain from the settings bus
//   ramp_k        : log2 of the ramp length, already clamped to 0..8
//   gain          : live gain, signed, registered
module gain_ramp_chan
    import magphase_gain_pkg::*;
#(
    parameter logic [15:0] GAIN_RESET = 16'd1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               apply_direct,
    input  logic               apply_ramp,
    input  logic               step_en,
    input  logic               snap,
    input  logic signed [15:0] shadow,
    input  logic [3:0]         ramp_k,
    output logic signed [15:0] gain
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W-1:0] step_next;
    logic signed [15:0]      target;
    logic signed [16:0]      diff;
    logic [3:0]              shamt;

    // Place a 16-bit gain in the integer field of the accumulator.
    function automatic logic signed [ACC_W-1:0] widen(input logic [15:0] g);
        return {{(ACC_W-GAIN_W-FRAC_BITS){g[15]}}, g, {FRAC_BITS{1'b0}}};
    endfunction

    // The step is diff * 2^(8-k) in accumulator units, i.e. diff/2^k gain
    // units, so 2^k steps land exactly on target*256 with no rounding.
    assign diff      = {shadow[15], shadow} - {gain[15], gain};
    assign shamt     = 4'(MAX_RAMP_LOG2) - ramp_k;
    assign step_next = $signed({{(ACC_W-17){diff[16]}}, diff}) <<< shamt;
    assign gain      = acc[FRAC_BITS+GAIN_W-1:FRAC_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= widen(GAIN_RESET);
            target <= GAIN_RESET;
            step   <= '0;
        end else if (apply_direct) begin
            target <= shadow;
            acc    <= widen(shadow);
        end else if (apply_ramp) begin
            // Restart from the truncated live value so a ramp that follows an
            // abort still has an integer start point and lands exactly.
            target <= shadow;
            step   <= step_next;
            acc    <= widen(gain);
        end else if (snap) begin
            acc <= widen(target);
        end else if (step_en) begin
            acc <= acc + step;
        end
    end

endmodule

// File: rtl/magphase_gain_ctrl.sv
// magphase_gain_ctrl
// Sequences the magnitude and phase gains feeding the magphase gain
// multipliers. Settings writes land in shadow registers; a commit applies
// both shadows together at a packet boundary of the monitored stream,
// optionally ramping linearly over 2^k accepted samples.
//   ce_clk, ce_rst_n : clock, asynchronous active-low reset
//   bus              : settings-bus write port and monitored stream handshake
//   mag_gain         : live magnitude gain, signed
//   phase_gain       : live phase gain, signed
//   busy             : sequencer is armed or ramping
//   commit_count     : number of applied commits, wraps
module magphase_gain_ctrl
    import magphase_gain_pkg::*;
#(
    parameter int          SR_MAG_GAIN   = DEF_SR_MAG_GAIN,
    parameter int          SR_PHASE_GAIN = DEF_SR_PHASE_GAIN,
    parameter int          SR_COMMIT     = DEF_SR_COMMIT,
    parameter int          SR_RAMP       = DEF_SR_RAMP,
    parameter logic [15:0] GAIN_RESET    = 16'd1024
) (
    input  logic                ce_clk,
    input  logic                ce_rst_n,
    magphase_gain_ctrl_if.slave bus,
    output logic signed [15:0]  mag_gain,
    output logic signed [15:0]  phase_gain,
    output logic                busy,
    output logic [15:0]         commit_count
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ARMED = ST_ARMED;
    localparam logic [1:0] S_RAMP  = ST_RAMP;

    logic [1:0]         state;
    logic               in_pkt;
    logic               pend;
    logic [8:0]         cnt;
    logic               ramp_en;
    logic [3:0]         ramp_k;
    logic signed [15:0] mag_shadow;
    logic signed [15:0] phase_shadow;

    logic hs;
    logic apply;
    logic commit_wr;
    logic abort_wr;
    logic last_step;
    logic unused_set_data;

    assign hs        = bus.mon_tvalid & bus.mon_tready;
    assign commit_wr = bus.set_stb & (bus.set_addr == 8'(SR_COMMIT)) & bus.set_data[0];
    assign abort_wr  = bus.set_stb & (bus.set_addr == 8'(SR_COMMIT)) & bus.set_data[1];

    // Safe to switch gains after the closing tlast beat, or on an idle cycle
    // while no packet is open.
    assign apply     = (state == S_ARMED) & ((hs & bus.mon_tlast) | (!in_pkt & !hs));
    assign last_step = (state == S_RAMP) & hs & (cnt == 9'd1);
    assign busy      = (state != S_IDLE);

    assign unused_set_data = ^bus.set_data[31:16];

    // Packet tracking: open on a non-last beat, closed by the tlast beat.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            in_pkt <= 1'b0;
        end else if (hs) begin
            in_pkt <= !bus.mon_tlast;
        end
    end

    // Shadow gains and ramp configuration; writable in every state. Ramp
    // settings are only consumed at apply, so changing them mid-ramp
    // affects the next commit only.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            mag_shadow   <= GAIN_RESET;
            phase_shadow <= GAIN_RESET;
            ramp_en      <= 1'b0;
            ramp_k       <= 4'd0;
        end else if (bus.set_stb) begin
            if (bus.set_addr == 8'(SR_MAG_GAIN)) begin
                mag_shadow <= bus.set_data[15:0];
            end
            if (bus.set_addr == 8'(SR_PHASE_GAIN)) begin
                phase_shadow <= bus.set_data[15:0];
            end
            if (bus.set_addr == 8'(SR_RAMP)) begin
                ramp_en <= bus.set_data[4];
                ramp_k  <= (bus.set_data[3:0] > 4'(MAX_RAMP_LOG2)) ?
                           4'(MAX_RAMP_LOG2) : bus.set_data[3:0];
            end
        end
    end

    // Commit sequencer. Abort wins over everything, including a commit bit
    // in the same word, and simply leaves the accumulators where they are.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state        <= S_IDLE;
            pend         <= 1'b0;
            cnt          <= 9'd0;
            commit_count <= 16'd0;
        end else if (abort_wr) begin
            state <= S_IDLE;
            pend  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (commit_wr) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (apply) begin
                        commit_count <= commit_count + 16'd1;
                        if (ramp_en) begin
                            cnt   <= 9'd1 << ramp_k;
                            state <= S_RAMP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RAMP: begin
                    if (commit_wr) begin
                        pend <= 1'b1;
                    end
                    if (hs) begin
                        cnt <= cnt - 9'd1;
                        if (cnt == 9'd1) begin
                            state <= (pend | commit_wr) ? S_ARMED : S_IDLE;
                            pend  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic apply_direct;
    logic apply_ramp;
    logic step_en;
    logic snap;

    assign apply_direct = apply & !ramp_en & !abort_wr;
    assign apply_ramp   = apply &  ramp_en & !abort_wr;
    assign snap         = last_step & !abort_wr;
    assign step_en      = (state == S_RAMP) & hs & (cnt != 9'd1) & !abort_wr;

    gain_ramp_chan #(.GAIN_RESET(GAIN_RESET)) u_mag_chan (
        .clk          (ce_clk),
        .rst_n        (ce_rst_n),
        .apply_direct (apply_direct),
        .apply_ramp   (apply_ramp),
        .step_en      (step_en),
        .snap         (snap),
        .shadow       (mag_shadow),
        .ramp_k       (ramp_k),
        .gain         (mag_gain)
    );

    gain_ramp_chan #(.GAIN_RESET(GAIN_RESET)) u_phase_chan (
        .clk          (ce_clk),
        .rst_n        (ce_rst_n),
        .apply_direct (apply_direct),
        .apply_ramp   (apply_ramp),
        .step_en      (step_en),
        .snap         (snap),
        .shadow       (phase_shadow),
        .ramp_k       (ramp_k),
        .gain         (phase_gain)
    );

endmodule

// File: tb/tb_magphase_gain_ctrl.sv
// tb_magphase_gain_ctrl
// Table-driven bench for magphase_gain_ctrl. Each row drives one cycle of
// settings/stream inputs and pushes the outputs expected after that clock
// edge onto a scoreboard queue; the queue is popped and compared one
// time unit after the edge.
module tb_magphase_gain_ctrl;

    localparam int A_MAG   = 192;
    localparam int A_PHASE = 193;
    localparam int A_CMT   = 194;
    localparam int A_RAMP  = 195;

    typedef struct {
        logic        stb;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        tv;
        logic        tr;
        logic        tl;
        logic [15:0] e_mag;
        logic [15:0] e_phase;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [15:0] mag;
        logic [15:0] phase;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    logic               ce_clk;
    logic               ce_rst_n;
    logic signed [15:0] mag_gain;
    logic signed [15:0] phase_gain;
    logic               busy;
    logic [15:0]        commit_count;

    magphase_gain_ctrl_if bus ();

    magphase_gain_ctrl dut (
        .ce_clk       (ce_clk),
        .ce_rst_n     (ce_rst_n),
        .bus          (bus.slave),
        .mag_gain     (mag_gain),
        .phase_gain   (phase_gain),
        .busy         (busy),
        .commit_count (commit_count)
    );

    int    n_compared;
    int    n_mismatched;
    string grp;
    int    row_idx;
    vec_t  vecs[$];
    exp_t  exp_q[$];

    // Free-running clock, 10 time units per period.
    initial begin
        ce_clk = 1'b0;
        forever #5 ce_clk = ~ce_clk;
    end

    function automatic vec_t mk(input logic stb, input int addr, input int data,
                                input logic tv, input logic tr, input logic tl,
                                input int mag, input int phase,
                                input logic bsy, input int cnt);
        vec_t r;
        r.stb     = stb;
        r.addr    = 8'(addr);
        r.data    = 32'(data);
        r.tv      = tv;
        r.tr      = tr;
        r.tl      = tl;
        r.e_mag   = 16'(mag);
        r.e_phase = 16'(phase);
        r.e_busy  = bsy;
        r.e_cnt   = 16'(cnt);
        return r;
    endfunction

    function automatic vec_t wr(input int addr, input int data, input int mag,
                                input int phase, input logic bsy, input int cnt);
        return mk(1'b1, addr, data, 1'b0, 1'b0, 1'b0, mag, phase, bsy, cnt);
    endfunction

    function automatic vec_t bt(input logic tl, input int mag, input int phase,
                                input logic bsy, input int cnt);
        return mk(1'b0, 0, 0, 1'b1, 1'b1, tl, mag, phase, bsy, cnt);
    endfunction

    function automatic vec_t idl(input int mag, input int phase,
                                 input logic bsy, input int cnt);
        return mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, mag, phase, bsy, cnt);
    endfunction

    function automatic vec_t stl(input int mag, input int phase,
                                 input logic bsy, input int cnt);
        return mk(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, mag, phase, bsy, cnt);
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s[%0d] %s: got %0d, required %0d", grp, row_idx, name,
                     $signed(act), $signed(req));
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s[%0d] scoreboard: got empty queue, required an entry",
                     grp, row_idx);
        end else begin
            e = exp_q.pop_front();
            cmp("mag_gain",     mag_gain,          e.mag);
            cmp("phase_gain",   phase_gain,        e.phase);
            cmp("busy",         {15'd0, busy},     {15'd0, e.busy});
            cmp("commit_count", commit_count,      e.cnt);
        end
    endtask

    task automatic drive_idle();
        bus.set_stb    = 1'b0;
        bus.set_addr   = 8'd0;
        bus.set_data   = 32'd0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tready = 1'b0;
        bus.mon_tlast  = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        @(negedge ce_clk);
        bus.set_stb    = v.stb;
        bus.set_addr   = v.addr;
        bus.set_data   = v.data;
        bus.mon_tvalid = v.tv;
        bus.mon_tready = v.tr;
        bus.mon_tlast  = v.tl;
        e.mag   = v.e_mag;
        e.phase = v.e_phase;
        e.busy  = v.e_busy;
        e.cnt   = v.e_cnt;
        exp_q.push_back(e);
        @(posedge ce_clk);
        #1;
        check_output();
    endtask

    task automatic run_table(input string name);
        grp = name;
        for (int i = 0; i < vecs.size(); i++) begin
            row_idx = i;
            apply_stimulus(vecs[i]);
        end
        vecs.delete();
        @(negedge ce_clk);
        drive_idle();
    endtask

    task automatic reset_dut();
        @(negedge ce_clk);
        drive_idle();
        ce_rst_n = 1'b0;
        #2;
        ce_rst_n = 1'b1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        row_idx      = 0;
        grp          = "init";
        drive_idle();
        ce_rst_n = 1'b0;
        #12;
        ce_rst_n = 1'b1;

        // Reset state, then a direct commit on an idle stream.
        vecs.push_back(idl(1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_MAG, 2048, 1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_CMT, 1,    1024, 1024, 1'b1, 0));
        vecs.push_back(idl(2048, 1024, 1'b0, 1));
        vecs.push_back(idl(2048, 1024, 1'b0, 1));
        run_table("idle_commit");

        // Commit at beat 3 of an 8-beat packet waits for the tlast beat,
        // including across a bubble and a stalled beat inside the packet.
        reset_dut();
        vecs.push_back(wr(A_MAG, 3000, 1024, 1024, 1'b0, 0));
        vecs.push_back(bt(1'b0, 1024, 1024, 1'b0, 0));
        vecs.push_back(bt(1'b0, 1024, 1024, 1'b0, 0));
        vecs.push_back(mk(1'b1, A_CMT, 1, 1'b1, 1'b1, 1'b0, 1024, 1024, 1'b1, 0));
        vecs.push_back(bt(1'b0, 1024, 1024, 1'b1, 0));
        vecs.push_back(bt(1'b0, 1024, 1024, 1'b1, 0));
        vecs.push_back(idl(1024, 1024, 1'b1, 0));
        vecs.push_back(stl(1024, 1024, 1'b1, 0));
        vecs.push_back(bt(1'b0, 1024, 1024, 1'b1, 0));
        vecs.push_back(bt(1'b0, 1024, 1024, 1'b1, 0));
        vecs.push_back(bt(1'b1, 3000, 1024, 1'b0, 1));
        vecs.push_back(idl(3000, 1024, 1'b0, 1));
        run_table("pkt_boundary");

        // Ramp k=2 upward: quarter steps, idle when tready is low.
        reset_dut();
        vecs.push_back(wr(A_RAMP, 32'h12, 1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_MAG,  2048,   1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_CMT,  1,      1024, 1024, 1'b1, 0));
        vecs.push_back(idl(1024, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 1280, 1024, 1'b1, 1));
        vecs.push_back(stl(1280, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 1536, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 1792, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 2048, 1024, 1'b0, 1));
        vecs.push_back(bt(1'b1, 2048, 1024, 1'b0, 1));
        run_table("ramp_k2");

        // Ramp k=3: magnitude falls to -1024 while phase rises to 2048.
        reset_dut();
        vecs.push_back(wr(A_RAMP,  32'h13,    1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_MAG,   32'hFC00,  1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_PHASE, 2048,      1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_CMT,   1,         1024, 1024, 1'b1, 0));
        vecs.push_back(idl(1024, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b0, 768, 1152, 1'b1, 1));
        vecs.push_back(stl(768, 1152, 1'b1, 1));
        vecs.push_back(bt(1'b0, 512, 1280, 1'b1, 1));
        vecs.push_back(bt(1'b0, 256, 1408, 1'b1, 1));
        vecs.push_back(bt(1'b0, 0,   1536, 1'b1, 1));
        vecs.push_back(stl(0, 1536, 1'b1, 1));
        vecs.push_back(idl(0, 1536, 1'b1, 1));
        vecs.push_back(bt(1'b0, -256,  1664, 1'b1, 1));
        vecs.push_back(bt(1'b0, -512,  1792, 1'b1, 1));
        vecs.push_back(bt(1'b0, -768,  1920, 1'b1, 1));
        vecs.push_back(bt(1'b0, -1024, 2048, 1'b0, 1));
        run_table("ramp_k3_neg");

        // Commit during a ramp: ramp completes, re-arms, then applies 512
        // directly (ramp turned off mid-ramp) at the next tlast beat.
        reset_dut();
        vecs.push_back(wr(A_RAMP, 32'h11, 1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_MAG,  2048,   1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_CMT,  1,      1024, 1024, 1'b1, 0));
        vecs.push_back(idl(1024, 1024, 1'b1, 1));
        vecs.push_back(wr(A_MAG,  512,    1024, 1024, 1'b1, 1));
        vecs.push_back(wr(A_CMT,  1,      1024, 1024, 1'b1, 1));
        vecs.push_back(wr(A_RAMP, 0,      1024, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 1536, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 2048, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b0, 2048, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 512,  1024, 1'b0, 2));
        run_table("commit_in_ramp");

        // Commit coincident with the tlast handshake applies on the next
        // idle cycle.
        reset_dut();
        vecs.push_back(wr(A_PHASE, 700, 1024, 1024, 1'b0, 0));
        vecs.push_back(bt(1'b0, 1024, 1024, 1'b0, 0));
        vecs.push_back(mk(1'b1, A_CMT, 1, 1'b1, 1'b1, 1'b1, 1024, 1024, 1'b1, 0));
        vecs.push_back(idl(1024, 700, 1'b0, 1));
        run_table("commit_on_tlast");

        // Oversized k clamps to 8: 256 steps of +1.
        reset_dut();
        vecs.push_back(wr(A_RAMP, 32'h1F, 1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_MAG,  1280,   1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_CMT,  1,      1024, 1024, 1'b1, 0));
        vecs.push_back(idl(1024, 1024, 1'b1, 1));
        for (int i = 1; i <= 256; i++) begin
            vecs.push_back(bt(1'b1, 1024 + i, 1024, (i < 256), 1));
        end
        run_table("ramp_k_clamp");

        // Abort mid-ramp freezes the gain; abort wins over commit in one
        // word; a fresh ramp restarts from the frozen value; then an
        // asynchronous reset mid-ramp.
        reset_dut();
        vecs.push_back(wr(A_RAMP, 32'h12, 1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_MAG,  2048,   1024, 1024, 1'b0, 0));
        vecs.push_back(wr(A_CMT,  1,      1024, 1024, 1'b1, 0));
        vecs.push_back(idl(1024, 1024, 1'b1, 1));
        vecs.push_back(bt(1'b1, 1280, 1024, 1'b1, 1));
        vecs.push_back(wr(A_CMT,  2,      1280, 1024, 1'b0, 1));
        vecs.push_back(bt(1'b1, 1280, 1024, 1'b0, 1));
        vecs.push_back(wr(A_CMT,  3,      1280, 1024, 1'b0, 1));
        vecs.push_back(idl(1280, 1024, 1'b0, 1));
        vecs.push_back(wr(A_CMT,  1,      1280, 1024, 1'b1, 1));
        vecs.push_back(idl(1280, 1024, 1'b1, 2));
        vecs.push_back(bt(1'b1, 1472, 1024, 1'b1, 2));
        grp = "abort_reset";
        for (int i = 0; i < vecs.size(); i++) begin
            row_idx = i;
            apply_stimulus(vecs[i]);
        end
        vecs.delete();

        // Still mid-ramp here: drop reset between edges and check at once.
        #2;
        ce_rst_n = 1'b0;
        #1;
        row_idx = 99;
        begin
            exp_t e;
            e.mag   = 16'd1024;
            e.phase = 16'd1024;
            e.busy  = 1'b0;
            e.cnt   = 16'd0;
            exp_q.push_back(e);
        end
        check_output();
        @(negedge ce_clk);
        drive_idle();
        ce_rst_n = 1'b1;

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL final scoreboard: got %0d leftover entries, required 0",
                     exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/magphase_gain_ctrl.md
# magphase_gain_ctrl

- Sequences the magnitude and phase gain values feeding the magphase gain multipliers.
- Gain writes on the settings bus are held in shadow registers.
- A commit applies both gains together at a packet boundary on the monitored sample stream, so no packet sees a gain change between beats.
- When ramping is enabled, the gains move from old to new values linearly over 2^k accepted samples.
- The block replaces the direct `setting_reg` gain registers and sits between the noc_shell settings bus and the two gain multipliers.

## Interface
Parameters:
- `SR_MAG_GAIN`, 192: settings address of the magnitude gain shadow register.
- `SR_PHASE_GAIN`, 193: settings address of the phase gain shadow register.
- `SR_COMMIT`, 194: commit/abort address. bit0 = commit, bit1 = abort.
- `SR_RAMP`, 195: ramp configuration. bits[3:0] = k (clamped to 8), bit4 = ramp enable.
- `GAIN_RESET`, 16'd1024: reset value of live and shadow gains.

Ports:
- `ce_clk` in 1: the single clock.
- `ce_rst_n` in 1: reset, asynchronous, active-low.
- `set_stb` in 1: settings write strobe.
- `set_addr` in 8: settings address.
- `set_data` in 32: settings data.
- `mon_tvalid` in 1: observed tvalid of the stream entering the multipliers.
- `mon_tready` in 1: observed tready of that stream.
- `mon_tlast` in 1: observed tlast of that stream.
- `mag_gain` out 16: live magnitude gain, signed.
- `phase_gain` out 16: live phase gain, signed.
- `busy` out 1: state is not IDLE.
- `commit_count` out 16: number of applied commits, wraps.

## Operation
- Beat handshake: `hs = mon_tvalid & mon_tready`.
- `in_pkt` register:
  - set on `hs & !mon_tlast`;
  - cleared on `hs & mon_tlast`;
  - reset value 0.
- Shadow registers:
  - Writes to `SR_MAG_GAIN` / `SR_PHASE_GAIN` load `set_data[15:0]` in any state.
  - They never affect the live gains directly.
- Ramp register: k = min(`set_data[3:0]`, 8), enable = `set_data[4]`.
- Boundary condition: `apply = (state==ARMED) & ((hs & mon_tlast) | (!in_pkt & !hs))`.
- FSM states: IDLE, ARMED, RAMP.
  - **IDLE**: a commit write goes to ARMED.
  - **ARMED**: on `apply`, both shadow values are latched as targets and `commit_count` increments.
    - Ramp disabled: both gains load their targets and the state goes to IDLE.
    - Ramp enabled: compute `step = (target − current) <<< (8−k)`, load `cnt = 2^k`, go to RAMP.
    - A further commit write has no effect; the newest shadow values are used at apply.
  - **RAMP**: each `hs` does `acc += step` per channel and `cnt−1`.
    - On the step where cnt reaches 0, both gains are forced to their targets.
    - Then go to ARMED if a commit arrived during RAMP (`pend` flag), otherwise IDLE.
- Abort write (bit1) in any state:
  - go to IDLE immediately;
  - live gains freeze at their current value;
  - `pend` clears.
  - Abort has priority over commit in the same word.
- Arithmetic:
  - `acc` is signed 26-bit with 8 fractional bits.
  - diff is 17-bit signed.
  - Output gain = `acc[23:8]`, truncated.
  - After 2^k steps `acc` equals target·256 exactly, so the value stays monotonic between the old and new gain and never overflows.
- Reset:
  - gains and shadows = `GAIN_RESET`;
  - state IDLE, `busy` 0, `commit_count` 0;
  - ramp disabled with k = 0;
  - `pend` 0, `in_pkt` 0.

## Timing
- All outputs are registered.
- A commit write in cycle N puts the state in ARMED at N+1.
- If the stream is idle (no packet in progress), `apply` occurs in N+1 and the new gain is visible in N+2.
- Boundary on the tlast beat in cycle M: that beat uses the old gain, and the new gain is visible from M+1.
- Ramp: each `hs` in cycle M updates the gain at M+1.
- The last ramp step lands on target; `busy` drops in the same cycle the final value appears.
- A commit write coincident with the tlast handshake is registered first and waits for the next boundary.
  - With no packet following, that is one cycle later, via `!in_pkt & !hs`.
- An asynchronous reset mid-ramp restores all reset values immediately.

## Structure
- Package `magphase_gain_pkg`:
  - SR address constants;
  - state enum;
  - `FRAC_BITS = 8`;
  - `MAX_RAMP_LOG2 = 8`.
- Sub-module `gain_ramp_chan`, instantiated twice (magnitude, phase): one accumulator, step calculation, and target snap.
- The FSM, counter and `in_pkt` tracking live in the top-level block.

## Test plan
- Idle stream: write mag = 2048, commit → `mag_gain` = 2048 two cycles after the commit strobe; `commit_count` = 1.
- 8-beat packet in flight, commit at beat 3 → beats 3–8 see 1024; the gain changes the cycle after the beat-8 tlast handshake.
- Ramp k = 2, 1024 → 2048 → after successive handshakes 1280, 1536, 1792, 2048; `busy` drops with 2048.
- Ramp k = 3, 1024 → −1024 (negative direction) → strictly decreasing, ending exactly at −1024; output stays idle between handshakes when tready is low.
- Commit during RAMP with new shadow = 512 → the ramp finishes, the state goes to ARMED, and 512 is applied at the next boundary; `commit_count` increments twice.
- Abort mid-ramp, then assert `ce_rst_n` low mid-ramp → abort freezes the current value and sets `busy` = 0; reset forces 1024/1024, `busy` 0 and `commit_count` 0 asynchronously.
